prbs6_checker: RTL and testbench

//  Receive-side checker for the 6-bit PRBS stream (polynomial x^6 + x^5 + 1, next = {w[4:0], w[5]^w[4]}).

---
 rtl/prbs6_pkg.sv | 24 ++
 rtl/sat_counter.sv | 32 +++
 rtl/prbs6_checker.sv | 144 ++++++++++++++
 tb/tb_prbs6_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prbs6_pkg.sv
//------------------------------------------------------------------------------
// Module   : prbs6_pkg
// Brief    : Shared PRBS6 (x^6 + x^5 + 1) types, width and next-word function.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package prbs6_pkg;

    localparam int PRBS6_W = 6;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } prbs6_state_e;

    // Also used by the generator side, so both ends step the LFSR identically.
    function automatic logic [PRBS6_W-1:0] prbs6_next(input logic [PRBS6_W-1:0] w);
        return {w[4:0], w[5] ^ w[4]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clear has priority over inc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/prbs6_checker.sv
//------------------------------------------------------------------------------
// Module   : prbs6_checker
// Brief    : Self-synchronising PRBS6 receive checker with flywheel predictor,
//            lock/unlock hysteresis and saturating error counter.
//            Define PRBS6_CHK_STATS_EN to add the 32-bit checked-word counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prbs6_checker
    import prbs6_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PRBS6_W-1:0] data_in,
    input  logic               clr_err,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_count,
    output logic [31:0]        word_count
);

    localparam logic [3:0] c_LOCK_CNT   = 4'(LOCK_CNT);
    localparam logic [3:0] c_UNLOCK_CNT = 4'(UNLOCK_CNT);

    prbs6_state_e       r_state;
    logic [PRBS6_W-1:0] r_pred;
    logic [3:0]         r_match_cnt;
    logic [3:0]         r_miss_cnt;
    logic               r_locked;
    logic               r_err_pulse;

    prbs6_state_e       w_state_nxt;
    logic [PRBS6_W-1:0] w_pred_nxt;
    logic [3:0]         w_match_nxt;
    logic [3:0]         w_miss_nxt;
    logic               w_err;
    logic               w_hit;

    assign w_hit = (data_in == r_pred);

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err       = 1'b0;

        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    // All-zero is the LFSR lockup word: never seed from it.
                    if (data_in == '0) begin
                        w_match_nxt = '0;
                    end else begin
                        w_pred_nxt = prbs6_next(data_in);
                        if (w_hit) begin
                            w_match_nxt = r_match_cnt + 4'd1;
                            if (r_match_cnt + 4'd1 == c_LOCK_CNT) begin
                                w_state_nxt = LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            w_match_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: keep stepping the predictor, not the received word.
                    w_pred_nxt = prbs6_next(r_pred);
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err      = 1'b1;
                        w_miss_nxt = r_miss_cnt + 4'd1;
                        if (r_miss_cnt + 4'd1 == c_UNLOCK_CNT) begin
                            w_state_nxt = HUNT;
                            w_match_nxt = '0;
                            w_pred_nxt  = prbs6_next(data_in);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_pred      <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err),
        .clr (clr_err),
        .q   (err_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;

`ifdef PRBS6_CHK_STATS_EN
    logic [31:0] r_word_count;
    logic        w_wc_inc;

    assign w_wc_inc = in_valid && (r_state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            r_word_count <= '0;
        end else if (w_wc_inc) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`else
    assign word_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs6_checker.sv
//------------------------------------------------------------------------------
// Module   : tb_prbs6_checker
// Brief    : Directed scoreboard bench for prbs6_checker (LOCK 4, UNLOCK 3, ERR_W 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prbs6_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  data_in;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [3:0]  err_count;
    logic [31:0] word_count;

    prbs6_checker #(
        .LOCK_CNT   (4),
        .UNLOCK_CNT (3),
        .ERR_W      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lk;
        logic       ep;
        logic [3:0] ec;
        logic       wc;
        string      name;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] cur;

    function automatic logic [5:0] nxt(input logic [5:0] w);
        return {w[4:0], w[5] ^ w[4]};
    endfunction

    // One clock of stimulus plus the expected outputs after the following edge.
    task automatic step(input logic v, input logic [5:0] d, input logic clr, input logic r,
                        input logic el, input logic ep, input logic [3:0] ec,
                        input logic wc, input string name);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        clr_err  = clr;
        rst      = r;
        e.lk = el; e.ep = ep; e.ec = ec; e.wc = wc; e.name = name;
        q.push_back(e);
    endtask

    // Monitor: consumes one expectation per edge that has stimulus queued.
    initial begin
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                #1;
                n_checks++;
                if (locked !== e.lk || err_pulse !== e.ep || err_count !== e.ec ||
                    (e.wc && word_count !== 32'd0)) begin
                    n_fail++;
                    $display("FAIL %s: got locked=%b err_pulse=%b err_count=%0d word_count=%0d, expected locked=%b err_pulse=%b err_count=%0d%s",
                             e.name, locked, err_pulse, err_count, word_count,
                             e.lk, e.ep, e.ec, e.wc ? " word_count=0" : "");
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = '0; clr_err = 1'b0;

        // Reset, with a valid word present to show reset dominates.
        step(1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "reset");
        step(1'b1, 6'h01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "reset_dominates");

        // 1: acquisition from seed 000001; lock visible after the 5th word.
        cur = 6'h01;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, cur, 1'b0, 1'b0, (i >= 4), 1'b0, 4'd0, 1'b0, "acquire");
            cur = nxt(cur);
        end

        // 2: single corrupted word, flywheel keeps the next good words matching.
        step(1'b1, cur ^ 6'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, "single_err");
        cur = nxt(cur);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, cur, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, "flywheel_good");
            cur = nxt(cur);
        end

        // 3: three consecutive errors drop lock; reseed word then four matches relock.
        step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "clr_idle");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, cur ^ 6'h01, 1'b0, 1'b0, (i < 2), 1'b1, 4'(i + 1), 1'b0, "burst_err");
            cur = nxt(cur);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, cur, 1'b0, 1'b0, (i >= 4), 1'b0, 4'd3, 1'b0, "relock");
            cur = nxt(cur);
        end

        // 4: lockup word in HUNT is ignored, then normal acquisition.
        step(1'b1, cur, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "reset_locked");
        for (int i = 0; i < 5; i++)
            step(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "zero_word_hunt");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, cur, 1'b0, 1'b0, (i >= 4), 1'b0, 4'd0, 1'b0, "lock_after_zero");
            cur = nxt(cur);
        end

        // 5: alternate bad/good to saturate the 4-bit error counter at 15.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, cur ^ 6'h01, 1'b0, 1'b0, 1'b1, 1'b1, (i >= 14) ? 4'd15 : 4'(i + 1), 1'b0, "saturate_bad");
            cur = nxt(cur);
            step(1'b1, cur, 1'b0, 1'b0, 1'b1, 1'b0, (i >= 14) ? 4'd15 : 4'(i + 1), 1'b0, "saturate_good");
            cur = nxt(cur);
        end
        step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "clr_after_sat");
        step(1'b1, cur ^ 6'h01, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, "clr_wins_err");
        cur = nxt(cur);
        step(1'b1, cur, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "after_clr_err");
        cur = nxt(cur);

        // 6: invalid gap holds everything, then reset mid-LOCKED and relock at a new phase.
        step(1'b1, cur ^ 6'h01, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, "pre_gap_err");
        cur = nxt(cur);
        for (int i = 0; i < 7; i++)
            step(1'b0, 6'h2A, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, "gap_hold");
        step(1'b1, cur, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, "post_gap_good");
        cur = nxt(cur);
        step(1'b1, cur ^ 6'h01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "reset_mid_lock");
        for (int i = 0; i < 5; i++) cur = nxt(cur);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, cur, 1'b0, 1'b0, (i >= 4), 1'b0, 4'd0, 1'b0, "relock_after_rst");
            cur = nxt(cur);
        end

        @(negedge clk);
        in_valid = 1'b0; clr_err = 1'b0; rst = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
